// File: rtl/prog_delay_pkg.sv
// Shared helpers for prog_delay_line: width functions, modular ring index and
// the cfg_err cause codes.
package prog_delay_pkg;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] BAD_CH   = 2'd1;
    localparam logic [1:0] CLAMP_LO = 2'd2;
    localparam logic [1:0] CLAMP_HI = 2'd3;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // (a - b) mod m for a < m and b <= m; one correction step is enough.
    function automatic int unsigned mod_sub(input int unsigned a, input int unsigned b,
                                            input int unsigned m);
        int signed diff;
        diff = int'(a) - int'(b);
        if (diff < 0) diff = diff + int'(m);
        return unsigned'(diff);
    endfunction

    function automatic logic [1:0] cfg_cause(input int unsigned ch, input int unsigned dly,
                                             input int unsigned n_ch,
                                             input int unsigned max_dly);
        if (ch >= n_ch) return BAD_CH;
        if (dly == 0) return CLAMP_LO;
        if (dly > max_dly) return CLAMP_HI;
        return ERR_NONE;
    endfunction

    function automatic int unsigned clamp_dly(input int unsigned dly, input int unsigned max_dly);
        if (dly == 0) return 1;
        if (dly > max_dly) return max_dly;
        return dly;
    endfunction

endpackage

// File: rtl/prog_delay_line_chan.sv
// One delay channel: {valid, data} ring, delay register, settle counter and output stage.
// Optional per-channel beat counter when DLY_STATS_EN is defined.
module prog_delay_chan
    import prog_delay_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned MAX_DELAY     = 16,
    parameter int unsigned DEFAULT_DELAY = 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [clog2_min1(MAX_DELAY)-1:0]     wptr_i,
    input  logic                                 in_valid_i,
    input  logic [WIDTH-1:0]                     in_data_i,
    input  logic                                 cfg_we_i,
    input  logic [$clog2(MAX_DELAY+1)-1:0]       cfg_dly_i,
    output logic                                 out_valid_o,
    output logic [WIDTH-1:0]                     out_data_o,
`ifdef DLY_STATS_EN
    output logic [15:0]                          stat_cnt_o,
`endif
    output logic                                 settling_o
);

    localparam int unsigned PW = clog2_min1(MAX_DELAY);
    localparam int unsigned DW = $clog2(MAX_DELAY + 1);

    logic [MAX_DELAY-1:0] ring_v_q;
    logic [WIDTH-1:0]     ring_d_q [MAX_DELAY];
    logic [DW-1:0]        dly_q;
    logic [DW-1:0]        settle_q;
    logic                 out_v_q;
    logic [WIDTH-1:0]     out_d_q;
    logic [PW-1:0]        rd_idx;

    assign rd_idx = PW'(mod_sub(32'(wptr_i), 32'(dly_q), MAX_DELAY));

    // Output is blanked on the write edge and for the whole settle window so that
    // samples captured under the old delay never surface.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ring_v_q <= '0;
            dly_q    <= DW'(DEFAULT_DELAY);
            settle_q <= '0;
            out_v_q  <= 1'b0;
            out_d_q  <= '0;
        end else begin
            ring_v_q[wptr_i] <= in_valid_i;
            if (cfg_we_i) begin
                dly_q    <= cfg_dly_i;
                settle_q <= cfg_dly_i;
            end else if (settle_q != '0) begin
                settle_q <= settle_q - 1'b1;
            end
            if (cfg_we_i || settle_q != '0) begin
                out_v_q <= 1'b0;
                out_d_q <= '0;
            end else begin
                out_v_q <= ring_v_q[rd_idx];
                out_d_q <= ring_v_q[rd_idx] ? ring_d_q[rd_idx] : '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        ring_d_q[wptr_i] <= in_data_i;
    end

    assign out_valid_o = out_v_q;
    assign out_data_o  = out_d_q;
    assign settling_o  = (settle_q != '0);

`ifdef DLY_STATS_EN
    logic [15:0] stat_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || cfg_we_i) begin
            stat_q <= '0;
        end else if (out_v_q && stat_q != 16'hFFFF) begin
            stat_q <= stat_q + 16'd1;
        end
    end

    assign stat_cnt_o = stat_q;
`endif

endmodule

// File: rtl/prog_delay_line.sv
// Multi-channel programmable clock-cycle delay line with a shared ring write pointer.
// Defining DLY_STATS_EN adds the stat_cnt per-channel beat counters.
module prog_delay_line
    import prog_delay_pkg::*;
#(
    parameter int unsigned CH            = 4,
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned MAX_DELAY     = 16,
    parameter int unsigned DEFAULT_DELAY = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [CH-1:0]                      in_valid,
    input  logic [CH*WIDTH-1:0]                in_data,
    input  logic                               cfg_we,
    input  logic [clog2_min1(CH)-1:0]          cfg_ch,
    input  logic [$clog2(MAX_DELAY+1)-1:0]     cfg_dly,
    output logic                               cfg_err,
    output logic [CH-1:0]                      out_valid,
    output logic [CH*WIDTH-1:0]                out_data,
`ifdef DLY_STATS_EN
    output logic [CH*16-1:0]                   stat_cnt,
`endif
    output logic [CH-1:0]                      settling
);

    localparam int unsigned PW = clog2_min1(MAX_DELAY);
    localparam int unsigned DW = $clog2(MAX_DELAY + 1);

    logic [PW-1:0] wptr_q, wptr_d;
    logic          cfg_err_q;
    logic [1:0]    cause;
    logic [DW-1:0] dly_eff;
    logic [CH-1:0] chan_we;

    // Explicit wrap so non-power-of-two depths work.
    always_comb begin
        wptr_d = (32'(wptr_q) == MAX_DELAY - 1) ? '0 : wptr_q + 1'b1;
    end

    always_comb begin
        cause   = cfg_cause(32'(cfg_ch), 32'(cfg_dly), CH, MAX_DELAY);
        dly_eff = DW'(clamp_dly(32'(cfg_dly), MAX_DELAY));
        chan_we = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            chan_we[c] = cfg_we && (cause != BAD_CH) && (32'(cfg_ch) == c);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            cfg_err_q <= cfg_we && (cause != ERR_NONE);
        end
    end

    assign cfg_err = cfg_err_q;

    for (genvar c = 0; c < CH; c++) begin : g_chan
        prog_delay_chan #(
            .WIDTH        (WIDTH),
            .MAX_DELAY    (MAX_DELAY),
            .DEFAULT_DELAY(DEFAULT_DELAY)
        ) u_chan (
            .clk_i      (clk),
            .rst_i      (rst),
            .wptr_i     (wptr_q),
            .in_valid_i (in_valid[c]),
            .in_data_i  (in_data[c*WIDTH +: WIDTH]),
            .cfg_we_i   (chan_we[c]),
            .cfg_dly_i  (dly_eff),
            .out_valid_o(out_valid[c]),
            .out_data_o (out_data[c*WIDTH +: WIDTH]),
`ifdef DLY_STATS_EN
            .stat_cnt_o (stat_cnt[c*16 +: 16]),
`endif
            .settling_o (settling[c])
        );
    end

endmodule

// File: tb/tb_prog_delay_line.sv
// Scoreboard bench for prog_delay_line: queue-based sample model plus a small CH=3
// instance for the out-of-range channel case.
module tb_prog_delay_line;
    import prog_delay_pkg::*;

    localparam int unsigned CH    = 4;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned MAXD  = 16;
    localparam int unsigned DEFD  = 1;
    localparam int unsigned CW    = 2;
    localparam int unsigned DW    = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [CH-1:0]       in_valid;
    logic [CH*WIDTH-1:0] in_data;
    logic                cfg_we;
    logic [CW-1:0]       cfg_ch;
    logic [DW-1:0]       cfg_dly;
    logic                cfg_err;
    logic [CH-1:0]       out_valid;
    logic [CH*WIDTH-1:0] out_data;
    logic [CH-1:0]       settling;

    logic                rst3;
    logic [2:0]          in_valid3;
    logic [23:0]         in_data3;
    logic                cfg_we3;
    logic [1:0]          cfg_ch3;
    logic [DW-1:0]       cfg_dly3;
    logic                cfg_err3;
    logic [2:0]          out_valid3;
    logic [23:0]         out_data3;
    logic [2:0]          settling3;
`ifdef DLY_STATS_EN
    logic [CH*16-1:0]    stat_cnt;
    logic [3*16-1:0]     stat_cnt3;
`endif

    prog_delay_line #(
        .CH(CH), .WIDTH(WIDTH), .MAX_DELAY(MAXD), .DEFAULT_DELAY(DEFD)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_dly  (cfg_dly),
        .cfg_err  (cfg_err),
        .out_valid(out_valid),
        .out_data (out_data),
`ifdef DLY_STATS_EN
        .stat_cnt (stat_cnt),
`endif
        .settling (settling)
    );

    // CH=3 leaves channel code 3 unused, so the rejected-channel path is reachable.
    prog_delay_line #(
        .CH(3), .WIDTH(WIDTH), .MAX_DELAY(MAXD), .DEFAULT_DELAY(DEFD)
    ) u_dut3 (
        .clk      (clk),
        .rst      (rst3),
        .in_valid (in_valid3),
        .in_data  (in_data3),
        .cfg_we   (cfg_we3),
        .cfg_ch   (cfg_ch3),
        .cfg_dly  (cfg_dly3),
        .cfg_err  (cfg_err3),
        .out_valid(out_valid3),
        .out_data (out_data3),
`ifdef DLY_STATS_EN
        .stat_cnt (stat_cnt3),
`endif
        .settling (settling3)
    );

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [31:0]      due;
    } exp_t;

    exp_t        exp_q [CH][$];
    int unsigned m_dly [CH];
    int unsigned settle_start [CH];
    int unsigned settle_end [CH];
    int signed   err_edge = -1;
    int unsigned edge_n   = 0;
    int          checks   = 0;
    int          errors   = 0;
    bit          mon_en   = 1'b0;

    // Reference: each sample is expected at (capture edge + current delay); a
    // reconfiguration drops everything pending and opens a settle window.
    task automatic model_edge();
        int signed   wc;
        int unsigned d;
        bit          err;
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                exp_q[c].delete();
                m_dly[c]        = DEFD;
                settle_start[c] = 0;
                settle_end[c]   = 0;
            end
            return;
        end
        wc = -1;
        if (cfg_we) begin
            d   = int'(cfg_dly);
            err = 1'b0;
            if (int'(cfg_ch) >= CH) begin
                err = 1'b1;
            end else begin
                if (d == 0) begin d = 1; err = 1'b1; end
                if (d > MAXD) begin d = MAXD; err = 1'b1; end
                wc                = int'(cfg_ch);
                m_dly[wc]         = d;
                settle_start[wc]  = edge_n;
                settle_end[wc]    = edge_n + d;
                exp_q[wc].delete();
            end
            if (err) err_edge = int'(edge_n);
        end
        for (int c = 0; c < CH; c++) begin
            if (c != wc && in_valid[c]) begin
                exp_q[c].push_back({in_data[c*WIDTH +: WIDTH], 32'(edge_n + m_dly[c])});
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        model_edge();
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t             e;
        logic [WIDTH-1:0] od;
        logic             exp_set;
        if (mon_en) begin
            for (int c = 0; c < CH; c++) begin
                od = out_data[c*WIDTH +: WIDTH];
                checks++;
                if (out_valid[c]) begin
                    if (exp_q[c].size() == 0) begin
                        errors++;
                        $display("FAIL out_ch%0d unexpected beat: got data %02h at edge %0d, required no beat",
                                 c, od, edge_n);
                    end else begin
                        e = exp_q[c].pop_front();
                        if (e.data !== od || e.due != edge_n) begin
                            errors++;
                            $display("FAIL out_ch%0d beat: got data %02h at edge %0d, required data %02h at edge %0d",
                                     c, od, edge_n, e.data, e.due);
                        end
                    end
                end else if (od !== '0) begin
                    errors++;
                    $display("FAIL out_ch%0d idle data: got %02h required 00 at edge %0d", c, od, edge_n);
                end else if (exp_q[c].size() != 0 && exp_q[c][0].due <= edge_n) begin
                    e = exp_q[c].pop_front();
                    errors++;
                    $display("FAIL out_ch%0d missing beat: got none at edge %0d, required data %02h",
                             c, edge_n, e.data);
                end
                exp_set = (edge_n >= settle_start[c]) && (edge_n < settle_end[c]);
                checks++;
                if (settling[c] !== exp_set) begin
                    errors++;
                    $display("FAIL settling_ch%0d: got %b required %b at edge %0d",
                             c, settling[c], exp_set, edge_n);
                end
            end
            checks++;
            if (cfg_err !== (err_edge == int'(edge_n))) begin
                errors++;
                $display("FAIL cfg_err: got %b required %b at edge %0d",
                         cfg_err, (err_edge == int'(edge_n)), edge_n);
            end
        end
    end

    task automatic idle();
        rst      = 1'b0;
        in_valid = '0;
        in_data  = $urandom;
        cfg_we   = 1'b0;
    endtask

    task automatic rand_inputs();
        in_valid = 4'($urandom);
        in_data  = $urandom;
    endtask

    task automatic write_cfg(input int unsigned ch, input int unsigned d);
        cfg_we  = 1'b1;
        cfg_ch  = CW'(ch);
        cfg_dly = DW'(d);
    endtask

    initial begin
        rst = 1'b1; in_valid = '0; in_data = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_dly = '0;
        rst3 = 1'b1; in_valid3 = '0; in_data3 = '0; cfg_we3 = 1'b0; cfg_ch3 = '0; cfg_dly3 = '0;
        for (int c = 0; c < CH; c++) begin
            m_dly[c] = DEFD; settle_start[c] = 0; settle_end[c] = 0;
        end

        tick();
        mon_en = 1'b1;
        tick();
        idle();
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_out_data", out_data, 32'h0);

        // Default delay of 1: sample at edge 10 is out after edge 11.
        while (edge_n < 9) tick();
        in_valid[0] = 1'b1;
        in_data     = 32'h0000_005A;
        tick();
        idle();
        tick();
        chk("default_dly_valid", 32'(out_valid), 32'h1);
        chk("default_dly_data", out_data, 32'h0000_005A);

        // Per-channel delays 1/5/16/3.
        write_cfg(0, 1); tick();
        write_cfg(1, 5); tick();
        write_cfg(2, 16); tick();
        write_cfg(3, 3); tick();
        idle();
        repeat (20) tick();
        in_valid = 4'hF;
        in_data  = 32'hA3A2_A1A0;
        tick();
        idle();
        repeat (20) tick();

        // Continuous ramp through ch2 at the maximum delay, across pointer wraps.
        for (int i = 0; i < 64; i++) begin
            rand_inputs();
            in_valid[2]     = 1'b1;
            in_data[23:16]  = 8'(i);
            tick();
        end
        idle();
        repeat (20) tick();

        // ch1 streaming at d=5, reprogrammed to d=2 mid-stream.
        for (int i = 0; i < 24; i++) begin
            idle();
            in_valid[1]    = 1'b1;
            in_data[15:8]  = 8'(8'h40 + i);
            if (i == 10) write_cfg(1, 2);
            tick();
        end
        idle();
        repeat (8) tick();

        // Clamped writes.
        write_cfg(3, 0); tick();
        write_cfg(0, 31); tick();
        for (int i = 0; i < 30; i++) begin
            idle();
            rand_inputs();
            tick();
        end

        // Random traffic with occasional (possibly out-of-range) reconfiguration.
        for (int i = 0; i < 300; i++) begin
            idle();
            rand_inputs();
            if ($urandom_range(0, 11) == 0) write_cfg($urandom_range(0, 3), $urandom_range(0, 31));
            tick();
        end

        // Reset while all channels hold in-flight samples.
        write_cfg(2, 16); tick();
        idle();
        repeat (16) tick();
        for (int i = 0; i < 10; i++) begin
            idle();
            in_valid = 4'hF;
            in_data  = $urandom;
            tick();
        end
        rst      = 1'b1;
        in_valid = 4'hF;
        write_cfg(1, 9);
        tick();
        idle();
        chk("midreset_out_valid", 32'(out_valid), 32'h0);
        chk("midreset_settling", 32'(settling), 32'h0);
        for (int i = 0; i < 30; i++) begin
            idle();
            rand_inputs();
            tick();
        end
        idle();
        repeat (20) tick();
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("drain_ch%0d", c), 32'(exp_q[c].size()), 32'h0);
        end

        // Out-of-range channel on the CH=3 instance: error pulse, no channel disturbed.
        rst3 = 1'b0;
        tick();
        cfg_we3 = 1'b1; cfg_ch3 = 2'd3; cfg_dly3 = 5'd5;
        in_valid3 = 3'b001; in_data3 = 24'h00_0077;
        tick();
        chk("badch_err", 32'(cfg_err3), 32'h1);
        chk("badch_settling", 32'(settling3), 32'h0);
        cfg_we3 = 1'b0; in_valid3 = '0;
        tick();
        chk("badch_err_pulse", 32'(cfg_err3), 32'h0);
        chk("badch_dly_kept_valid", 32'(out_valid3), 32'h1);
        chk("badch_dly_kept_data", 32'(out_data3), 32'h77);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
